// File: rtl/asmi_arbiter_if.sv
// rtl/asmi_arbiter_if.sv - signal bundle between asmi_arbiter, its two requesters and the ASMI read port
//
// Purpose: groups the programmer handshake, the flash-reader request/response
// signals and the ASMI read-side signals so the arbiter takes one bus port.
// Ports (all carried as interface signals):
//   prog_req, prog_done, prog_grant           programmer ownership handshake
//   rd_req, rd_addr, rd_len                   reader request (rd_req is a one-clock pulse)
//   rd_data, rd_valid, rd_done, timeout_err   reader response stream
//   asmi_busy, asmi_data_valid, asmi_dataout  ASMI status and read data
//   asmi_addr, asmi_rden, asmi_read           ASMI read controls driven by the arbiter
// Modports: slave = the arbiter itself, master = requesters plus the ASMI.

interface asmi_arbiter_if;
    logic        prog_req;
    logic        prog_done;
    logic        prog_grant;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic [7:0]  rd_len;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_done;
    logic        timeout_err;
    logic        asmi_busy;
    logic        asmi_data_valid;
    logic [7:0]  asmi_dataout;
    logic [23:0] asmi_addr;
    logic        asmi_rden;
    logic        asmi_read;

    modport slave (
        input  prog_req, prog_done, rd_req, rd_addr, rd_len,
        input  asmi_busy, asmi_data_valid, asmi_dataout,
        output prog_grant, rd_data, rd_valid, rd_done, timeout_err,
        output asmi_addr, asmi_rden, asmi_read
    );

    modport master (
        output prog_req, prog_done, rd_req, rd_addr, rd_len,
        output asmi_busy, asmi_data_valid, asmi_dataout,
        input  prog_grant, rd_data, rd_valid, rd_done, timeout_err,
        input  asmi_addr, asmi_rden, asmi_read
    );
endinterface

// File: rtl/asmi_arbiter.sv
// rtl/asmi_arbiter.sv - grants the single ASMI flash port to the programmer or the flash reader
//
// Purpose: one owner of the ASMI at a time. The programmer gets the port via
// prog_grant (also the ASMI mux select); reads are run by this block directly.
// A guard of GUARD idle clocks follows every ASMI busy fall before the next
// grant, and a watchdog aborts reads that stall for TIMEOUT clocks.
// Ports:
//   clock  in  system clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    asmi_arbiter_if.slave - requester handshakes and ASMI read port

module asmi_arbiter #(
    parameter int GUARD   = 2,
    parameter int TIMEOUT = 25000000
) (
    input logic           clock,
    input logic           reset,
    asmi_arbiter_if.slave bus
);
    localparam int              GW         = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [GW-1:0]   GUARD_LAST = GW'(GUARD - 1);
    localparam logic [24:0]     WD_LAST    = 25'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PROG, S_PROG_WAIT, S_RD_SETUP,
        S_RD_START, S_RD_DATA, S_RD_WAIT, S_GUARD
    } state_t;

    state_t        r_state,  w_state;
    logic          r_grant,  w_grant;
    logic [23:0]   r_addr,   w_addr;
    logic          r_rden,   w_rden;
    logic          r_read,   w_read;
    logic [7:0]    r_data,   w_data;
    logic          r_valid,  w_valid;
    logic          r_done,   w_done;
    logic          r_terr,   w_terr;
    logic [8:0]    r_cnt,    w_cnt;
    logic [24:0]   r_wd,     w_wd;
    logic [GW-1:0] r_gcnt,   w_gcnt;
    logic          r_abort,  w_abort;

    // ASMI shifts bytes LSB first; the reader wants normal bit order.
    function automatic logic [7:0] bit_rev(input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) y[i] = x[7-i];
        return y;
    endfunction

    always_comb begin
        w_state = r_state;
        w_grant = r_grant;
        w_addr  = r_addr;
        w_rden  = r_rden;
        w_read  = 1'b0;
        w_data  = r_data;
        w_valid = 1'b0;
        w_done  = 1'b0;
        w_terr  = 1'b0;
        w_cnt   = r_cnt;
        w_wd    = r_wd;
        w_gcnt  = r_gcnt;
        w_abort = r_abort;
        case (r_state)
            S_IDLE: begin
                if (!bus.asmi_busy) begin
                    if (bus.prog_req) begin
                        // programmer wins a tie; the rd_req pulse is simply lost
                        w_state = S_PROG;
                        w_grant = 1'b1;
                    end else if (bus.rd_req) begin
                        // address/length captured on the accepting edge so RD_SETUP
                        // already presents them with rden high
                        w_state = S_RD_SETUP;
                        w_addr  = bus.rd_addr;
                        w_cnt   = (bus.rd_len == 8'd0) ? 9'd256 : {1'b0, bus.rd_len};
                        w_rden  = 1'b1;
                        w_wd    = 25'd0;
                        w_abort = 1'b0;
                    end
                end
            end
            S_PROG: begin
                if (bus.prog_done) w_state = S_PROG_WAIT;
            end
            S_PROG_WAIT: begin
                if (!bus.asmi_busy) begin
                    w_grant = 1'b0;
                    w_gcnt  = '0;
                    w_state = S_GUARD;
                end
            end
            S_RD_SETUP: begin
                w_read  = 1'b1;
                w_state = S_RD_START;
            end
            S_RD_START: begin
                w_state = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (bus.asmi_data_valid) begin
                    w_data  = bit_rev(bus.asmi_dataout);
                    w_valid = 1'b1;
                    w_cnt   = r_cnt - 9'd1;
                    w_wd    = 25'd0;
                    if (r_cnt == 9'd1) begin
                        w_rden  = 1'b0;
                        w_state = S_RD_WAIT;
                    end
                end else if (r_wd == WD_LAST) begin
                    // abort reports rd_done now; RD_WAIT then exits silently
                    w_rden  = 1'b0;
                    w_terr  = 1'b1;
                    w_done  = 1'b1;
                    w_abort = 1'b1;
                    w_state = S_RD_WAIT;
                end else begin
                    w_wd = r_wd + 25'd1;
                end
            end
            S_RD_WAIT: begin
                if (!bus.asmi_busy) begin
                    w_done  = !r_abort;
                    w_gcnt  = '0;
                    w_state = S_GUARD;
                end
            end
            S_GUARD: begin
                if (bus.asmi_busy)               w_gcnt  = '0;
                else if (r_gcnt == GUARD_LAST)   w_state = S_IDLE;
                else                             w_gcnt  = r_gcnt + 1'b1;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
            r_addr  <= 24'd0;
            r_rden  <= 1'b0;
            r_read  <= 1'b0;
            r_data  <= 8'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_terr  <= 1'b0;
            r_cnt   <= 9'd0;
            r_wd    <= 25'd0;
            r_gcnt  <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state;
            r_grant <= w_grant;
            r_addr  <= w_addr;
            r_rden  <= w_rden;
            r_read  <= w_read;
            r_data  <= w_data;
            r_valid <= w_valid;
            r_done  <= w_done;
            r_terr  <= w_terr;
            r_cnt   <= w_cnt;
            r_wd    <= w_wd;
            r_gcnt  <= w_gcnt;
            r_abort <= w_abort;
        end
    end

    assign bus.prog_grant  = r_grant;
    assign bus.asmi_addr   = r_addr;
    assign bus.asmi_rden   = r_rden;
    assign bus.asmi_read   = r_read;
    assign bus.rd_data     = r_data;
    assign bus.rd_valid    = r_valid;
    assign bus.rd_done     = r_done;
    assign bus.timeout_err = r_terr;
endmodule

// File: doc/asmi_arbiter.md
# asmi_arbiter

Shares the single ASMI flash megafunction (EPCS16) between two requesters: the firmware-update programmer (sector erase / page program) and a short-burst flash reader used to fetch stored configuration bytes (MAC/IP settings, image headers). Grants the ASMI to one requester at a time and drives the ASMI read port itself. Enforces the two-clock guard after ASMI `busy` clears before any new operation, and aborts stalled reads with a watchdog.

## Interface
Parameters:
- `GUARD`, 2: idle clocks required after `asmi_busy` falls before the next grant.
- `TIMEOUT`, 25000000: clocks without `asmi_data_valid` in a read before abort (25-bit counter).

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `prog_req`  in  1  programmer requests ASMI ownership (level).
- `prog_done`  in  1  programmer releases ownership (level, sampled only while granted).
- `prog_grant`  out  1  programmer owns ASMI; also the ASMI mux select (1 = programmer drives addr/wren/erase/write/shift_bytes).
- `rd_req`  in  1  read request (single-clock pulse).
- `rd_addr`  in  24  read start byte address.
- `rd_len`  in  8  bytes to read; 0 means 256.
- `rd_data`  out  8  read byte, bit order restored (ASMI bit 7 → `rd_data[0]`).
- `rd_valid`  out  1  `rd_data` valid, one clock per byte.
- `rd_done`  out  1  one-clock pulse ending a read (normal or aborted).
- `timeout_err`  out  1  one-clock pulse, coincident with `rd_done`, on watchdog abort.
- `asmi_busy`  in  1  ASMI busy.
- `asmi_data_valid`  in  1  ASMI read byte valid.
- `asmi_dataout`  in  8  ASMI read byte (LSB-first order).
- `asmi_addr`  out  24  ASMI address when reader owns the port.
- `asmi_rden`  out  1  ASMI read enable.
- `asmi_read`  out  1  ASMI read start strobe.

## Operation
- States: IDLE, PROG, PROG_WAIT, RD_SETUP, RD_START, RD_DATA, RD_WAIT, GUARD.
- IDLE: accepts a request only when `asmi_busy`=0. Simultaneous `prog_req` and `rd_req`: programmer wins; the `rd_req` pulse is dropped (the requester retries on no `rd_done`). `rd_req` while not in IDLE is ignored.
- PROG: `prog_grant`=1. On `prog_done`=1 → PROG_WAIT; `prog_grant` stays 1 until `asmi_busy`=0, then drops and → GUARD. `prog_req` deasserting without `prog_done` is ignored; ownership ends only by `prog_done` or reset.
- RD_SETUP: latch `rd_addr` → `asmi_addr`; latch `rd_len` into 9-bit remaining count (0 → 256); `asmi_rden`=1.
- RD_START: `asmi_read`=1 for exactly one clock; → RD_DATA.
- RD_DATA: each `asmi_data_valid` → `rd_data`=bit-reverse(`asmi_dataout`), `rd_valid`=1 next clock, count decrements, watchdog clears. Count reaches 0 → `asmi_rden`=0, → RD_WAIT. Watchdog reaching `TIMEOUT` → `asmi_rden`=0, `timeout_err`=1, `rd_done`=1, → RD_WAIT.
- RD_WAIT: wait `asmi_busy`=0; `rd_done` pulses on exit for normal completion; → GUARD.
- GUARD: count `GUARD` clocks with `asmi_busy`=0 (restart count if busy reasserts); → IDLE.
- Address wrap past 24'hFFFFFF is left to the ASMI; the arbiter only supplies the start address.
- `asmi_addr` holds its last value outside reads; the ASMI mux ignores it while `prog_grant`=1.

## Timing
- Reset: state IDLE; `prog_grant`, `rd_valid`, `rd_done`, `timeout_err`, `asmi_rden`, `asmi_read`=0; `asmi_addr`, `rd_data`=0; counters 0. Reset mid-read drops `asmi_rden` immediately with no `rd_done`. Reset mid-program drops `prog_grant`.
- `prog_req` sampled at edge N in IDLE → `prog_grant`=1 after edge N+1.
- `rd_req` at edge N → `asmi_rden`=1 after N+1, `asmi_read`=1 during N+2 only.
- `asmi_data_valid` at edge M → `rd_valid`/`rd_data` after M+1 (one-clock latency).
- Minimum gap from `asmi_busy` fall to next grant/`rd_req` acceptance: `GUARD`+1 clocks.
- `rd_done` and `prog_grant` are never high in the same clock.

## Test plan
- Read 4 bytes at 24'h1F0000, ASMI model returns 8'h01,8'h80,8'hF0,8'hAA → `rd_data` 8'h80,8'h01,8'h0F,8'h55, four `rd_valid` pulses, one `rd_done`, `asmi_read` high exactly 1 clock.
- `rd_len`=0 → exactly 256 `rd_valid` pulses, then `asmi_rden` falls and `rd_done` pulses once.
- `prog_req` and `rd_req` on the same edge → `prog_grant`=1 next clock, no read activity. `prog_done` while `asmi_busy`=1 for 10 clocks → grant holds through busy, then 2 guard clocks, then IDLE.
- Read where the model never asserts `asmi_data_valid` (`TIMEOUT` overridden to 100) → after 100 clocks `timeout_err` and `rd_done` pulse together, `asmi_rden`=0.
- `reset` asserted at byte 3 of a 16-byte read → next clock all outputs 0, no `rd_done`; a new `rd_req` is then accepted normally.
- `asmi_busy` re-pulsing during GUARD → guard count restarts; `rd_req` during GUARD ignored (no `rd_done`).
